// File: rtl/roc_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | roc_decoder: AER receiver for the rank-order-coded spike link.            |
// | Rebuilds an intensity image from index arrival order.                      |
// | Optional macro: ROC_DECODER_REQ_SYNC_EN (2-flop REQ synchronizer).         |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module roc_decoder #(
  parameter int         IMAGE_SIZE      = 256,
  parameter int         IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int         PIXEL_MAX_VALUE = 255,
  parameter int         PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE + 1),
  parameter logic [9:0] AER_MARKER      = 10'h1FF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       AERIN_REQ,
  input  logic [9:0]                 AERIN_ADDR,
  output logic                       AERIN_ACK,
  input  logic                       FLUSH,
  output logic [PIXEL_BITS-1:0]      DECODED_IMAGE [0:IMAGE_SIZE-1],
  output logic                       IMAGE_RDY,
  output logic [IMAGE_SIZE_BITS:0]   RANK_CNT,
  output logic [7:0]                 ERR_CNT
);

  typedef enum logic [0:0] {H_WAIT = 1'b0, H_ACK = 1'b1} hstate_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_COLLECT = 2'd2, S_DONE = 2'd3} dstate_t;

  logic                     w_req;
  hstate_t                  r_hstate, w_hstate_nxt;
  logic                     r_ack, w_ack_nxt;
  logic                     r_evt_vld, w_evt_nxt;
  logic [9:0]               r_addr;

  dstate_t                  r_dstate, w_dstate_nxt;
  logic                     r_rdy;
  logic [IMAGE_SIZE_BITS:0] r_rank;
  logic [7:0]               r_err;
  logic [IMAGE_SIZE-1:0]    r_seen;
  logic [PIXEL_BITS-1:0]    r_image [0:IMAGE_SIZE-1];

  logic                       w_marker, w_in_range, w_last;
  logic [IMAGE_SIZE_BITS-1:0] w_idx;
  logic [PIXEL_BITS-1:0]      w_pix_val;
  logic                       w_clear, w_write, w_drop, w_rdy_set, w_rdy_clr;

`ifdef ROC_DECODER_REQ_SYNC_EN
  logic r_req_meta, r_req_sync;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_req_meta <= 1'b0;
      r_req_sync <= 1'b0;
    end else begin
      r_req_meta <= AERIN_REQ;
      r_req_sync <= r_req_meta;
    end
  end

  assign w_req = r_req_sync;
`else
  assign w_req = AERIN_REQ;
`endif

  // Handshake: every event is acknowledged, evt_vld pulses once per capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hstate  <= H_WAIT;
      r_ack     <= 1'b0;
      r_evt_vld <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_hstate  <= w_hstate_nxt;
      r_ack     <= w_ack_nxt;
      r_evt_vld <= w_evt_nxt;
      if (w_evt_nxt) r_addr <= AERIN_ADDR;
    end
  end

  always_comb begin
    w_hstate_nxt = r_hstate;
    w_ack_nxt    = r_ack;
    w_evt_nxt    = 1'b0;
    case (r_hstate)
      H_WAIT: begin
        if (w_req) begin
          w_hstate_nxt = H_ACK;
          w_ack_nxt    = 1'b1;
          w_evt_nxt    = 1'b1;
        end
      end
      H_ACK: begin
        w_ack_nxt = 1'b1;
        if (!w_req) begin
          w_hstate_nxt = H_WAIT;
          w_ack_nxt    = 1'b0;
        end
      end
      default: begin
        w_hstate_nxt = H_WAIT;
        w_ack_nxt    = 1'b0;
      end
    endcase
  end

  assign w_marker   = (r_addr == AER_MARKER);
  assign w_in_range = (32'(r_addr) < IMAGE_SIZE);
  assign w_idx      = r_addr[IMAGE_SIZE_BITS-1:0];
  assign w_last     = (32'(r_rank) == IMAGE_SIZE - 1);

  // Ranks beyond the brightness range all map to black.
  always_comb begin
    w_pix_val = '0;
    if (32'(r_rank) <= PIXEL_MAX_VALUE)
      w_pix_val = PIXEL_BITS'(PIXEL_MAX_VALUE - 32'(r_rank));
  end

  always_ff @(posedge CLK) begin
    if (RST) r_dstate <= S_IDLE;
    else     r_dstate <= w_dstate_nxt;
  end

  always_comb begin
    w_dstate_nxt = r_dstate;
    w_clear      = 1'b0;
    w_write      = 1'b0;
    w_drop       = 1'b0;
    w_rdy_set    = 1'b0;
    w_rdy_clr    = 1'b0;
    if (r_evt_vld) begin
      case (r_dstate)
        S_IDLE: begin
          if (w_marker) w_dstate_nxt = S_ARMED;
        end
        S_ARMED: begin
          if (w_marker) begin
            w_dstate_nxt = S_COLLECT;
            w_clear      = 1'b1;
          end else begin
            w_dstate_nxt = S_IDLE;
          end
        end
        S_COLLECT: begin
          if (w_marker) begin
            w_dstate_nxt = S_ARMED;
          end else if (w_in_range && !r_seen[w_idx]) begin
            w_write = 1'b1;
            if (w_last) begin
              w_dstate_nxt = S_DONE;
              w_rdy_set    = 1'b1;
            end
          end else begin
            w_drop = 1'b1;
          end
        end
        S_DONE: begin
          if (w_marker) begin
            w_dstate_nxt = S_ARMED;
            w_rdy_clr    = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end
        default: w_dstate_nxt = S_IDLE;
      endcase
    end
    // A coincident event still takes effect; FLUSH then closes the image.
    if (FLUSH && (r_dstate == S_COLLECT)) begin
      w_dstate_nxt = S_DONE;
      w_rdy_set    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rdy  <= 1'b0;
      r_rank <= '0;
      r_err  <= '0;
      r_seen <= '0;
      for (int i = 0; i < IMAGE_SIZE; i++) r_image[i] <= '0;
    end else begin
      if (w_rdy_set)      r_rdy <= 1'b1;
      else if (w_rdy_clr) r_rdy <= 1'b0;

      if (w_clear) begin
        r_rank <= '0;
        r_seen <= '0;
        for (int i = 0; i < IMAGE_SIZE; i++) r_image[i] <= '0;
      end else if (w_write) begin
        r_image[w_idx] <= w_pix_val;
        r_seen[w_idx]  <= 1'b1;
        r_rank         <= r_rank + 1'b1;
      end

      if (w_drop && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
    end
  end

  assign AERIN_ACK     = r_ack;
  assign IMAGE_RDY     = r_rdy;
  assign RANK_CNT      = r_rank;
  assign ERR_CNT       = r_err;
  assign DECODED_IMAGE = r_image;

endmodule
`default_nettype wire

// File: tb/tb_roc_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_roc_decoder: table-driven, scoreboarded bench for roc_decoder.         |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_roc_decoder;

  logic       CLK = 1'b0;
  logic       RST, AERIN_REQ, FLUSH;
  logic [9:0] AERIN_ADDR;
  logic       AERIN_ACK, IMAGE_RDY;
  logic [8:0] RANK_CNT;
  logic [7:0] ERR_CNT;
  logic [7:0] DECODED_IMAGE [0:255];

  always #5 CLK = ~CLK;

  roc_decoder dut (
    .CLK(CLK), .RST(RST), .AERIN_REQ(AERIN_REQ), .AERIN_ADDR(AERIN_ADDR),
    .AERIN_ACK(AERIN_ACK), .FLUSH(FLUSH), .DECODED_IMAGE(DECODED_IMAGE),
    .IMAGE_RDY(IMAGE_RDY), .RANK_CNT(RANK_CNT), .ERR_CNT(ERR_CNT)
  );

  typedef struct {
    logic [9:0] addr;
    logic       flush;
    int         rank;
    int         err;
    logic       rdy;
    int         idx;
    int         val;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vq[$];
  vec_t sb[$];

  function automatic vec_t mk(logic [9:0] a, logic f, int r, int e, logic rd, int i, int v);
    vec_t t;
    t.addr = a; t.flush = f; t.rank = r; t.err = e; t.rdy = rd; t.idx = i; t.val = v;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int nonzero_pixels();
    int n = 0;
    for (int i = 0; i < 256; i++) if (DECODED_IMAGE[i] != 8'd0) n++;
    return n;
  endfunction

  task automatic handshake(input logic [9:0] a, input logic fl);
    @(negedge CLK);
    AERIN_ADDR = a;
    AERIN_REQ  = 1'b1;
    check("ack_before_edge", 32'(AERIN_ACK), 0);
    @(posedge CLK); #1;
    check("ack_rise", 32'(AERIN_ACK), 1);
    @(negedge CLK);
    AERIN_REQ = 1'b0;
    FLUSH     = fl;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    check("ack_fall", 32'(AERIN_ACK), 0);
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    sb.push_back(v);
    handshake(v.addr, v.flush);
    e = sb.pop_front();
    check($sformatf("rank after %03h", e.addr), 32'(RANK_CNT), e.rank);
    check($sformatf("err after %03h", e.addr), 32'(ERR_CNT), e.err);
    check($sformatf("rdy after %03h", e.addr), 32'(IMAGE_RDY), 32'(e.rdy));
    check($sformatf("pix[%0d] after %03h", e.idx, e.addr), 32'(DECODED_IMAGE[e.idx]), e.val);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Main sequence after the first marker (decoder is ARMED at that point).
    vq.push_back(mk(10'h1FF, 1'b0, 0, 0, 1'b0, 5,   0));
    vq.push_back(mk(10'h005, 1'b0, 1, 0, 1'b0, 5,   255));
    vq.push_back(mk(10'h003, 1'b0, 2, 0, 1'b0, 3,   254));
    vq.push_back(mk(10'h0C8, 1'b0, 3, 0, 1'b0, 200, 253));
    vq.push_back(mk(10'h007, 1'b0, 4, 0, 1'b0, 7,   252));
    vq.push_back(mk(10'h007, 1'b0, 4, 1, 1'b0, 7,   252));
    vq.push_back(mk(10'h120, 1'b0, 4, 2, 1'b0, 32,  0));
    vq.push_back(mk(10'h100, 1'b0, 4, 3, 1'b0, 0,   0));
    vq.push_back(mk(10'h0FF, 1'b0, 5, 3, 1'b0, 255, 251));
    vq.push_back(mk(10'h1FF, 1'b0, 5, 3, 1'b0, 5,   255));
    vq.push_back(mk(10'h010, 1'b0, 5, 3, 1'b0, 16,  0));
    vq.push_back(mk(10'h020, 1'b0, 5, 3, 1'b0, 32,  0));
    vq.push_back(mk(10'h1FF, 1'b0, 5, 3, 1'b0, 3,   254));
    vq.push_back(mk(10'h1FF, 1'b0, 0, 3, 1'b0, 200, 0));
    for (int i = 0; i < 10; i++)
      vq.push_back(mk(10'(i), 1'b0, i + 1, 3, 1'b0, i, 255 - i));
    vq.push_back(mk(10'h00A, 1'b1, 11, 3, 1'b1, 10, 245));
    vq.push_back(mk(10'h00B, 1'b0, 11, 4, 1'b1, 11, 0));
    vq.push_back(mk(10'h1FF, 1'b0, 11, 4, 1'b0, 10, 245));
    vq.push_back(mk(10'h1FF, 1'b0, 0,  4, 1'b0, 10, 0));

    RST = 1'b1; AERIN_REQ = 1'b0; AERIN_ADDR = '0; FLUSH = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset ack", 32'(AERIN_ACK), 0);
    check("reset rdy", 32'(IMAGE_RDY), 0);
    check("reset rank", 32'(RANK_CNT), 0);
    check("reset err", 32'(ERR_CNT), 0);
    check("reset nonzero pixels", nonzero_pixels(), 0);
    @(negedge CLK);
    RST = 1'b0;

    // Marker held for five cycles: one event, ACK tracks REQ with one-cycle lag.
    @(negedge CLK);
    AERIN_ADDR = 10'h1FF;
    AERIN_REQ  = 1'b1;
    check("hold ack before edge", 32'(AERIN_ACK), 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      check($sformatf("hold ack cycle %0d", c), 32'(AERIN_ACK), 1);
    end
    @(negedge CLK);
    AERIN_REQ = 1'b0;
    check("hold ack at req drop", 32'(AERIN_ACK), 1);
    @(posedge CLK); #1;
    check("hold ack fall", 32'(AERIN_ACK), 0);

    foreach (vq[i]) run_vec(vq[i]);

    // Full image in reverse index order: pixel value equals its index.
    for (int k = 0; k < 256; k++)
      run_vec(mk(10'(255 - k), 1'b0, k + 1, 4, (k == 255), 255 - k, 255 - k));
    for (int i = 0; i < 256; i++)
      check($sformatf("full pix[%0d]", i), 32'(DECODED_IMAGE[i]), i);

    // FLUSH outside COLLECT has no effect.
    @(negedge CLK);
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    check("flush in done rdy", 32'(IMAGE_RDY), 1);
    check("flush in done rank", 32'(RANK_CNT), 256);

    // Drops in DONE drive ERR_CNT into saturation; image stays frozen.
    for (int k = 0; k < 260; k++)
      run_vec(mk(10'h000, 1'b0, 256, (5 + k > 255) ? 255 : 5 + k, 1'b1, 255, 255));

    // Reset while ACK is high.
    @(negedge CLK);
    AERIN_ADDR = 10'h005;
    AERIN_REQ  = 1'b1;
    @(posedge CLK); #1;
    check("midhs ack high", 32'(AERIN_ACK), 1);
    @(negedge CLK);
    RST       = 1'b1;
    AERIN_REQ = 1'b0;
    @(posedge CLK); #1;
    check("midhs ack", 32'(AERIN_ACK), 0);
    check("midhs rdy", 32'(IMAGE_RDY), 0);
    check("midhs rank", 32'(RANK_CNT), 0);
    check("midhs err", 32'(ERR_CNT), 0);
    check("midhs nonzero pixels", nonzero_pixels(), 0);
    @(negedge CLK);
    RST = 1'b0;
    // Two markers then an index only write if the decoder restarted in IDLE.
    run_vec(mk(10'h1FF, 1'b0, 0, 0, 1'b0, 4, 0));
    run_vec(mk(10'h1FF, 1'b0, 0, 0, 1'b0, 4, 0));
    run_vec(mk(10'h004, 1'b0, 1, 0, 1'b0, 4, 255));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/roc_decoder.md
Name: roc_decoder

Overview:
- AER receiver at the far end of the 10-bit rank-order-coded spike link.
- Completes a 4-phase REQ/ACK handshake per event and detects the two-marker start sequence.
- Rebuilds an intensity image from arrival order: the first index received gets the brightest value.
- Used as a loopback checker for the encoder and as the input stage of image-reconstruction debug.

Parameters:
IMAGE_SIZE, 256, number of pixels / valid index range 0..IMAGE_SIZE-1
IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), pixel index width
PIXEL_MAX_VALUE, 255, value assigned to rank 0
PIXEL_BITS, $clog2(PIXEL_MAX_VALUE+1), decoded pixel width
AER_MARKER, 10'h1FF, start-sequence address ({1'b0,1'b1,8'hFF})

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
AERIN_REQ  in  1  AER request, 4-phase
AERIN_ADDR  in  10  AER address, stable while AERIN_REQ=1
AERIN_ACK  out  1  AER acknowledge
FLUSH  in  1  one-cycle pulse: sender stopped early (inference done), close current image
DECODED_IMAGE  out  [PIXEL_BITS-1:0] x [0:IMAGE_SIZE-1]  reconstructed image
IMAGE_RDY  out  1  high while a completed image is held
RANK_CNT  out  IMAGE_SIZE_BITS+1  indices accepted in current image
ERR_CNT  out  8  dropped events (duplicate/out-of-range), saturating

Behaviour:
- Reset (synchronous, CLK edge with RST=1): AERIN_ACK=0, IMAGE_RDY=0, DECODED_IMAGE all 0, RANK_CNT=0, ERR_CNT=0, seen-bits cleared, state IDLE, handshake in H_WAIT. Reset mid-handshake drops ACK; the event in flight is discarded.
- Handshake FSM:
  - H_WAIT: on edge with AERIN_REQ=1, latch addr_q<=AERIN_ADDR, AERIN_ACK<=1, evt_vld<=1 (single-cycle pulse), go to H_ACK.
  - H_ACK: hold ACK=1 until AERIN_REQ sampled 0; next edge ACK<=0, return to H_WAIT.
  - ACK rises 1 cycle after REQ sampled high and falls 1 cycle after REQ sampled low.
  - Every event is acknowledged, including dropped ones. No back-pressure.
- Decode FSM, advanced only on evt_vld (evaluated the cycle after capture):
  - IDLE: marker -> ARMED; other addr ignored (no ERR_CNT increment).
  - ARMED: marker -> COLLECT, clearing DECODED_IMAGE, seen-bits and RANK_CNT in the same edge; non-marker -> IDLE.
  - COLLECT, addr < IMAGE_SIZE with seen[addr]=0: DECODED_IMAGE[addr] <= PIXEL_MAX_VALUE - RANK_CNT, saturating to 0 if RANK_CNT > PIXEL_MAX_VALUE. Set seen[addr]; RANK_CNT++. If RANK_CNT becomes IMAGE_SIZE -> DONE and IMAGE_RDY<=1 on the same edge.
  - COLLECT, addr >= IMAGE_SIZE (non-marker) or seen[addr]=1: drop; ERR_CNT++ saturating at 255.
  - COLLECT, marker: abort current image -> ARMED. IMAGE_RDY stays 0; partial image is kept until the next COLLECT entry.
  - DONE: IMAGE_RDY=1, image frozen. Marker -> ARMED, IMAGE_RDY<=0. Non-marker dropped with ERR_CNT++.
- FLUSH: valid in COLLECT only -> DONE, IMAGE_RDY<=1; unsent pixels remain 0. Ignored in other states.
- FLUSH and evt_vld on the same edge: the event is processed first (written if valid), then state -> DONE.
- ERR_CNT is cleared only by RST.

Optional Feature:
ROC_DECODER_REQ_SYNC_EN
- Defined: AERIN_REQ passes through a 2-flop synchronizer before the handshake FSM, adding 2 cycles to the ACK-rise and ACK-fall latencies. AERIN_ADDR is latched when the synchronized REQ is 1.
- Undefined: AERIN_REQ is used directly (same-clock-domain sender), with latencies as specified above.

Test Plan:
- RST, then REQ=1 addr=0x1FF held 5 cycles -> ACK=1 exactly 1 cycle after REQ sampled; REQ=0 -> ACK=0 one cycle later; state ARMED.
- Two markers, then indices 5, 3, 200 -> DECODED_IMAGE[5]=255, [3]=254, [200]=253, all others 0; RANK_CNT=3; IMAGE_RDY=0.
- Two markers, then all 256 indices in order 255..0 -> IMAGE_RDY=1 after the 256th event; pixel[i]=i; RANK_CNT=256.
- In COLLECT, send 7, 7, 0x120 -> pixel[7]=255; ERR_CNT=2; RANK_CNT=1; all three events acknowledged.
- In COLLECT after 10 indices, FLUSH pulse coincident with 11th event -> 11th written as 245; IMAGE_RDY=1; a later marker drops IMAGE_RDY; a second marker clears the image.
- RST asserted while ACK=1 -> next cycle ACK=0, IMAGE_RDY=0, image all 0, ERR_CNT=0, IDLE.
